// File: rtl/decoder_round_controller_pkg.sv
// Shared definitions for the decoder round controller.
//   round_state_t      : round sequencing states
//   match_value_width  : width of one packed {y,x} match value
//   cell_index/cell_y/cell_x : row-major cell <-> coordinate conversion
//   max_int            : helper for counter sizing
package decoder_round_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    OFFER_START,
    OFFER_WAIT,
    STOP,
    CAPTURE,
    SCAN
  } round_state_t;

  function automatic int match_value_width(input int cord_width);
    return 2 * cord_width;
  endfunction

  function automatic int cell_index(input int y, input int x, input int width);
    return y * width + x;
  endfunction

  function automatic int cell_y(input int idx, input int width);
    return idx / width;
  endfunction

  function automatic int cell_x(input int idx, input int width);
    return idx % width;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_result_scanner.sv
// Snapshot of the grid's defect flags and match values, and the row-major
// scan that turns them into one valid/ready match record per defect.
// Build option: define PAIR_DEDUP_EN to report each mutual in-grid pair
// once, from the lower cell index.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   capture               load snapshot from measurement_in/match_value_in
//   scan_active           controller is in SCAN
//   measurement_in        per-cell defect flags from the grid
//   match_value_in        per-cell {y,x} match values
//   result_*              record stream to the downstream consumer
//   scan_done             final record handshaken this cycle
module decoder_result_scanner
  import decoder_round_controller_pkg::*;
#(
  parameter int GRID_HEIGHT       = 2,
  parameter int GRID_WIDTH        = 3,
  parameter int CORDINATE_WIDTH   = 2,
  parameter int MATCH_VALUE_WIDTH = match_value_width(CORDINATE_WIDTH)
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 capture,
  input  logic                                                 scan_active,
  input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                    measurement_in,
  input  logic [GRID_HEIGHT*GRID_WIDTH*MATCH_VALUE_WIDTH-1:0]  match_value_in,
  output logic                                                 result_valid,
  input  logic                                                 result_ready,
  output logic [CORDINATE_WIDTH-1:0]                           result_y,
  output logic [CORDINATE_WIDTH-1:0]                           result_x,
  output logic [CORDINATE_WIDTH-1:0]                           result_match_y,
  output logic [CORDINATE_WIDTH-1:0]                           result_match_x,
  output logic                                                 result_empty,
  output logic                                                 result_last,
  output logic                                                 scan_done
);

  localparam int N     = GRID_HEIGHT * GRID_WIDTH;
  localparam int CW    = CORDINATE_WIDTH;
  localparam int MVW   = MATCH_VALUE_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     snap_flag;
  logic [N*MVW-1:0] snap_match;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     emit;
  logic             any_emit;
  logic             cur_emit;
  logic             more_after;
  logic [MVW-1:0]   cur_match;

  // NOTE: the snapshot is a handful of flops, so it is reset like any other
  // state; that keeps result_* defined before the first capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_flag  <= '0;
      snap_match <= '0;
    end else if (capture) begin
      snap_flag  <= measurement_in;
      snap_match <= match_value_in;
    end
  end

`ifdef PAIR_DEDUP_EN
  // Cell i is the upper half of a mutual pair: its in-grid partner j sits
  // below it, is itself a defect, and points straight back at cell i.
  function automatic logic pair_suppressed(input int i,
                                           input logic [N-1:0] flags,
                                           input logic [N*MVW-1:0] matches);
    int my;
    int mx;
    int j;
    logic [MVW-1:0] own;
    my  = int'(matches[i*MVW+CW +: CW]);
    mx  = int'(matches[i*MVW +: CW]);
    own = {CW'(cell_y(i, GRID_WIDTH)), CW'(cell_x(i, GRID_WIDTH))};
    pair_suppressed = 1'b0;
    if (flags[i] && my < GRID_HEIGHT && mx < GRID_WIDTH) begin
      j = cell_index(my, mx, GRID_WIDTH);
      if (j < i && flags[j] && matches[j*MVW +: MVW] == own)
        pair_suppressed = 1'b1;
    end
  endfunction

  always_comb begin
    emit = snap_flag;
    for (int i = 0; i < N; i++)
      if (pair_suppressed(i, snap_flag, snap_match)) emit[i] = 1'b0;
  end
`else
  assign emit = snap_flag;
`endif

  always_comb begin
    any_emit   = |emit;
    cur_emit   = emit[idx];
    cur_match  = snap_match[int'(idx)*MVW +: MVW];
    more_after = 1'b0;
    for (int i = 0; i < N; i++)
      if (i > int'(idx) && emit[i]) more_after = 1'b1;

    result_valid   = 1'b0;
    result_empty   = 1'b0;
    result_last    = 1'b0;
    result_y       = '0;
    result_x       = '0;
    result_match_y = '0;
    result_match_x = '0;
    if (scan_active) begin
      if (!any_emit) begin
        // Nothing to report: a single empty record closes the round.
        result_valid = 1'b1;
        result_empty = 1'b1;
        result_last  = 1'b1;
      end else if (cur_emit) begin
        result_valid   = 1'b1;
        result_last    = !more_after;
        result_y       = CW'(cell_y(int'(idx), GRID_WIDTH));
        result_x       = CW'(cell_x(int'(idx), GRID_WIDTH));
        result_match_y = cur_match[MVW-1 -: CW];
        result_match_x = cur_match[CW-1:0];
      end
    end
    scan_done = result_valid && result_ready && result_last;
  end

  // Skip non-reporting cells one per cycle; stop on a reporting cell until
  // it is accepted. The index never moves past the last reporting cell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (capture) begin
      idx <= '0;
    end else if (scan_active && any_emit &&
                 (!cur_emit || (result_ready && more_after))) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/decoder_round_controller.sv
// Initiator side of the single-grid decoder interface. Accepts a syndrome
// frame, loads it into the grid, sequences start/stop offers with
// programmable budgets, snapshots the result and streams match records.
// Build option: PAIR_DEDUP_EN (see decoder_result_scanner).
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   syndrome_in/valid/ready          upstream frame handshake (ready in IDLE)
//   measurement_value_out/valid_out  registered frame and its load pulse
//   start_offer, stop_offer          one-cycle grid control pulses
//   measurement_in, match_value_in   grid results (sampled in CAPTURE only)
//   result_*                         downstream record stream
//   busy                             a round is in progress
module decoder_round_controller
  import decoder_round_controller_pkg::*;
#(
  parameter int GRID_HEIGHT       = 2,
  parameter int GRID_WIDTH        = 3,
  parameter int CORDINATE_WIDTH   = 2,
  parameter int MATCH_VALUE_WIDTH = match_value_width(CORDINATE_WIDTH),
  parameter int SETTLE_CYCLES     = 100,
  parameter int OFFER_CYCLES      = 2500
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                    syndrome_in,
  input  logic                                                 syndrome_valid,
  output logic                                                 syndrome_ready,
  output logic [GRID_HEIGHT*GRID_WIDTH-1:0]                    measurement_value_out,
  output logic                                                 measurement_valid_out,
  output logic                                                 start_offer,
  output logic                                                 stop_offer,
  input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                    measurement_in,
  input  logic [GRID_HEIGHT*GRID_WIDTH*MATCH_VALUE_WIDTH-1:0]  match_value_in,
  output logic                                                 result_valid,
  input  logic                                                 result_ready,
  output logic [CORDINATE_WIDTH-1:0]                           result_y,
  output logic [CORDINATE_WIDTH-1:0]                           result_x,
  output logic [CORDINATE_WIDTH-1:0]                           result_match_y,
  output logic [CORDINATE_WIDTH-1:0]                           result_match_x,
  output logic                                                 result_empty,
  output logic                                                 result_last,
  output logic                                                 busy
);

  localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, OFFER_CYCLES) + 1);

  round_state_t     state_q;
  round_state_t     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             scan_done;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counter value k in SETTLE/OFFER_WAIT means k cycles have elapsed since
  // the LOAD/OFFER_START pulse, so leaving at budget-1 lands the next pulse
  // exactly one budget after the previous one.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (syndrome_valid) state_d = LOAD;
      LOAD:        state_d = (SETTLE_CYCLES <= 1) ? OFFER_START : SETTLE;
      SETTLE:      if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = OFFER_START;
      OFFER_START: state_d = (OFFER_CYCLES <= 1) ? STOP : OFFER_WAIT;
      OFFER_WAIT:  if (cnt_q == CNT_W'(OFFER_CYCLES - 1)) state_d = STOP;
      STOP:        state_d = CAPTURE;
      CAPTURE:     state_d = SCAN;
      SCAN:        if (scan_done) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        LOAD, OFFER_START:  cnt_q <= CNT_W'(1);
        SETTLE, OFFER_WAIT: cnt_q <= cnt_q + CNT_W'(1);
        default:            cnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                measurement_value_out <= '0;
    else if (state_q == IDLE && syndrome_valid) measurement_value_out <= syndrome_in;
  end

  assign syndrome_ready        = (state_q == IDLE);
  assign busy                  = (state_q != IDLE);
  assign measurement_valid_out = (state_q == LOAD);
  assign start_offer           = (state_q == OFFER_START);
  assign stop_offer            = (state_q == STOP);

  decoder_result_scanner #(
    .GRID_HEIGHT       (GRID_HEIGHT),
    .GRID_WIDTH        (GRID_WIDTH),
    .CORDINATE_WIDTH   (CORDINATE_WIDTH),
    .MATCH_VALUE_WIDTH (MATCH_VALUE_WIDTH)
  ) u_scanner (
    .clk            (clk),
    .reset          (reset),
    .capture        (state_q == CAPTURE),
    .scan_active    (state_q == SCAN),
    .measurement_in (measurement_in),
    .match_value_in (match_value_in),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_y       (result_y),
    .result_x       (result_x),
    .result_match_y (result_match_y),
    .result_match_x (result_match_x),
    .result_empty   (result_empty),
    .result_last    (result_last),
    .scan_done      (scan_done)
  );

endmodule

// File: tb/tb_decoder_round_controller.sv
// Self-checking bench for decoder_round_controller (default parameters).
// Expected records come from a list-building model of the reporting rules;
// pulse timing is checked against the accept cycle plus the two budgets.
module tb_decoder_round_controller;

  localparam int H   = 2;
  localparam int W   = 3;
  localparam int CW  = 2;
  localparam int MVW = 4;
  localparam int N   = H * W;
  localparam int MW  = N * MVW;
  localparam int S   = 100;
  localparam int O   = 2500;
  localparam logic [21:0] RESET_OUTS = {1'b1, 21'b0};

  typedef struct packed {
    logic [CW-1:0] y;
    logic [CW-1:0] x;
    logic [CW-1:0] my;
    logic [CW-1:0] mx;
    logic          empty;
    logic          last;
  } rec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  syndrome_in;
  logic          syndrome_valid;
  logic          syndrome_ready;
  logic [N-1:0]  measurement_value_out;
  logic          measurement_valid_out;
  logic          start_offer;
  logic          stop_offer;
  logic [N-1:0]  measurement_in;
  logic [MW-1:0] match_value_in;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] result_y;
  logic [CW-1:0] result_x;
  logic [CW-1:0] result_match_y;
  logic [CW-1:0] result_match_x;
  logic          result_empty;
  logic          result_last;
  logic          busy;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder_round_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .syndrome_in           (syndrome_in),
    .syndrome_valid        (syndrome_valid),
    .syndrome_ready        (syndrome_ready),
    .measurement_value_out (measurement_value_out),
    .measurement_valid_out (measurement_valid_out),
    .start_offer           (start_offer),
    .stop_offer            (stop_offer),
    .measurement_in        (measurement_in),
    .match_value_in        (match_value_in),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .result_y              (result_y),
    .result_x              (result_x),
    .result_match_y        (result_match_y),
    .result_match_x        (result_match_x),
    .result_empty          (result_empty),
    .result_last           (result_last),
    .busy                  (busy)
  );

  // Reference: list every defect cell in row-major order, drop the upper
  // member of a mutual in-grid pair when dedup is built in, mark the tail.
  function automatic void build_expected(input logic [N-1:0] flags, input logic [MW-1:0] m);
    rec_t r;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      if (flags[c]) begin
        int y  = c / W;
        int x  = c % W;
        int my = int'(m[c*MVW+CW +: CW]);
        int mx = int'(m[c*MVW +: CW]);
        bit keep = 1'b1;
`ifdef PAIR_DEDUP_EN
        if (my < H && mx < W) begin
          int p = my * W + mx;
          if (p < c && flags[p] && int'(m[p*MVW+CW +: CW]) == y && int'(m[p*MVW +: CW]) == x)
            keep = 1'b0;
        end
`endif
        if (keep) exp_q.push_back('{y: CW'(y), x: CW'(x), my: CW'(my), mx: CW'(mx), empty: 1'b0, last: 1'b0});
      end
    end
    if (exp_q.size() == 0) begin
      exp_q.push_back('{y: '0, x: '0, my: '0, mx: '0, empty: 1'b1, last: 1'b1});
    end else begin
      r = exp_q[exp_q.size()-1];
      r.last = 1'b1;
      exp_q[exp_q.size()-1] = r;
    end
  endfunction

  task automatic drive_garbage();
    measurement_in = N'($urandom);
    match_value_in = MW'($urandom);
  endtask

  function automatic logic [21:0] all_outs();
    return {syndrome_ready, busy, measurement_valid_out, start_offer, stop_offer,
            result_valid, result_empty, result_last, measurement_value_out,
            result_y, result_x, result_match_y, result_match_x};
  endfunction

  // Called at a negedge; returns at the negedge where the frame is offered
  // with ready high (accepted on the next rising edge).
  task automatic accept_frame(input logic [N-1:0] syn, output int t_acc);
    syndrome_in    = syn;
    syndrome_valid = 1'b1;
    for (int n = 0; n < 20 && syndrome_ready !== 1'b1; n++) @(negedge clk);
    tests++;
    if (syndrome_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: got %b want 1", syndrome_ready);
    end
    t_acc = cyc;
  endtask

  // Follows the round from acceptance to the CAPTURE cycle, where the grid
  // values are driven; garbage is on the grid inputs at every other time.
  task automatic watch_sequence(input logic [N-1:0] syn, input logic [MW-1:0] gm, input int t_acc,
                                input bit keep_valid, input logic [N-1:0] next_syn);
    int t_mv = -1, t_start = -1, t_stop = -1;
    int w_mv = 0, w_start = 0, w_stop = 0;
    int busy_low = 0, rdy_high = 0, early_valid = 0;
    logic [N-1:0] mv_val = '0;
    for (int n = 0; n < S + O + 8; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (keep_valid) syndrome_in = next_syn;
        else            syndrome_valid = 1'b0;
      end
      if (measurement_valid_out) begin
        w_mv++;
        if (t_mv < 0) begin t_mv = cyc; mv_val = measurement_value_out; end
      end
      if (start_offer) begin w_start++; if (t_start < 0) t_start = cyc; end
      if (stop_offer)  begin w_stop++;  if (t_stop < 0)  t_stop  = cyc; end
      if (!busy) busy_low++;
      if (syndrome_ready) rdy_high++;
      if (result_valid) early_valid++;
      if (t_stop >= 0 && cyc > t_stop) begin
        measurement_in = syn;
        match_value_in = gm;
        break;
      end
      drive_garbage();
    end
    tests++; if (t_mv !== t_acc + 1) begin fails++; $display("FAIL seq_mv_time: got %0d want %0d", t_mv, t_acc + 1); end
    tests++; if (t_start !== t_acc + 1 + S) begin fails++; $display("FAIL seq_start_time: got %0d want %0d", t_start, t_acc + 1 + S); end
    tests++; if (t_stop !== t_acc + 1 + S + O) begin fails++; $display("FAIL seq_stop_time: got %0d want %0d", t_stop, t_acc + 1 + S + O); end
    tests++; if (w_mv != 1 || w_start != 1 || w_stop != 1) begin
      fails++; $display("FAIL seq_pulse_width: got mv=%0d start=%0d stop=%0d want 1 each", w_mv, w_start, w_stop);
    end
    tests++; if (mv_val !== syn) begin fails++; $display("FAIL seq_frame: got %b want %b", mv_val, syn); end
    tests++; if (busy_low != 0 || rdy_high != 0 || early_valid != 0) begin
      fails++; $display("FAIL seq_busy: got busy_low=%0d ready_high=%0d early_valid=%0d want 0 each", busy_low, rdy_high, early_valid);
    end
  endtask

  // Collects records from SCAN; bp<0 gives random ready, otherwise ready is
  // held low for the first bp valid cycles.
  task automatic collect(input logic [N-1:0] syn, input logic [MW-1:0] gm, input int bp);
    rec_t got[$];
    rec_t cur;
    rec_t prev = '0;
    bit   pending = 1'b0;
    bit   done = 1'b0;
    int   n_valid = 0;
    build_expected(syn, gm);
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      drive_garbage();
      cur = {result_y, result_x, result_match_y, result_match_x, result_empty, result_last};
      if (pending) begin
        tests++;
        if (result_valid !== 1'b1 || cur !== prev) begin
          fails++; $display("FAIL hold_stable: got valid=%b rec=%h want valid=1 rec=%h", result_valid, cur, prev);
        end
      end
      if (result_valid === 1'b1) begin
        if (bp < 0) result_ready = 1'($urandom_range(0, 1));
        else        result_ready = (n_valid >= bp);
        n_valid++;
        if (result_ready) begin
          got.push_back(cur);
          done = result_last;
        end
        pending = !result_ready;
        prev    = cur;
      end else begin
        result_ready = 1'($urandom_range(0, 1));
        pending      = 1'b0;
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL scan_timeout: got %0d records, no last", got.size()); end
    @(negedge clk);
    result_ready = 1'b0;
    tests++; if (busy !== 1'b0 || syndrome_ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL round_end: got busy=%b ready=%b valid=%b want 0 1 0", busy, syndrome_ready, result_valid);
    end
    tests++; if (got.size() != exp_q.size()) begin
      fails++; $display("FAIL record_count: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL record_%0d: got y=%0d x=%0d my=%0d mx=%0d empty=%b last=%b want y=%0d x=%0d my=%0d mx=%0d empty=%b last=%b",
                 i, got[i].y, got[i].x, got[i].my, got[i].mx, got[i].empty, got[i].last,
                 exp_q[i].y, exp_q[i].x, exp_q[i].my, exp_q[i].mx, exp_q[i].empty, exp_q[i].last);
      end
    end
  endtask

  task automatic do_round(input logic [N-1:0] syn, input logic [MW-1:0] gm, input int bp);
    int t_acc;
    accept_frame(syn, t_acc);
    watch_sequence(syn, gm, t_acc, 1'b0, '0);
    collect(syn, gm, bp);
  endtask

  task automatic test_reset();
    #1;
    tests++; if (all_outs() !== RESET_OUTS) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", all_outs(), RESET_OUTS);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (all_outs() !== RESET_OUTS) begin
      fails++; $display("FAIL reset_idle: got %h want %h", all_outs(), RESET_OUTS);
    end
  endtask

  task automatic test_sequencing();
    do_round(6'b101101, MW'($urandom), 0);
  endtask

  task automatic test_pair();
    logic [MW-1:0] gm = MW'($urandom);
    gm[3:0] = 4'b0001;   // (0,0) -> (0,1)
    gm[7:4] = 4'b0000;   // (0,1) -> (0,0)
    do_round(6'b000011, gm, 0);
  endtask

  task automatic test_zero();
    do_round(6'b000000, MW'($urandom), 0);
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] gm = MW'($urandom);
    gm[3:0]   = 4'b1111; // boundary match
    gm[23:20] = 4'b0011; // boundary match
    do_round(6'b100001, gm, 5);
  endtask

  task automatic test_reset_mid_round();
    int t_acc;
    int seen_start = -1;
    int pulses = 0;
    int busy_hi = 0;
    accept_frame(6'b010110, t_acc);
    for (int n = 0; n < S + 10 && seen_start < 0; n++) begin
      @(negedge clk);
      syndrome_valid = 1'b0;
      drive_garbage();
      if (start_offer) seen_start = cyc;
    end
    tests++; if (seen_start < 0) begin fails++; $display("FAIL abort_start_seen: got none want %0d", t_acc + 1 + S); end
    repeat (50) begin @(negedge clk); drive_garbage(); end
    reset = 1'b0;
    #1;
    tests++; if (all_outs() !== RESET_OUTS) begin
      fails++; $display("FAIL abort_outputs: got %h want %h", all_outs(), RESET_OUTS);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < S + O + 10; n++) begin
      @(negedge clk);
      drive_garbage();
      if (measurement_valid_out || start_offer || stop_offer || result_valid) pulses++;
      if (busy) busy_hi++;
    end
    tests++; if (pulses != 0 || busy_hi != 0) begin
      fails++; $display("FAIL abort_quiet: got pulses=%0d busy=%0d want 0 0", pulses, busy_hi);
    end
    do_round(6'b110010, MW'($urandom), -1);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  a = 6'b011001;
    logic [N-1:0]  b = 6'b100110;
    logic [MW-1:0] ga = MW'($urandom);
    logic [MW-1:0] gb = MW'($urandom);
    int t_acc;
    accept_frame(a, t_acc);
    watch_sequence(a, ga, t_acc, 1'b1, b);
    collect(a, ga, -1);
    // syndrome_valid is still high: the next frame goes in on this cycle.
    t_acc = cyc;
    watch_sequence(b, gb, t_acc, 1'b0, '0);
    collect(b, gb, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) do_round(N'($urandom), MW'($urandom), -1);
  endtask

  initial begin
    reset          = 1'b0;
    syndrome_in    = '0;
    syndrome_valid = 1'b0;
    result_ready   = 1'b0;
    measurement_in = '0;
    match_value_in = '0;
    test_reset();
    test_sequencing();
    test_pair();
    test_zero();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
